// File: rtl/cdb_complete_buffer_if.sv
// Execute-to-CDB bus bundle for the complete stage.
// master = execute/consumer side, slave = complete buffer.
interface cdb_complete_buffer_if #(
  parameter int N_EX     = 3,
  parameter int N_WAY    = 2,
  parameter int CDB_BITS = 6,
  parameter int XLEN     = 32
);
  logic [N_EX-1:0]                ex_valid;
  logic [N_EX-1:0][CDB_BITS-1:0]  ex_dest_tag;
  logic [N_EX-1:0][XLEN-1:0]      ex_result;
  logic                           ex_stall;
  logic [N_WAY-1:0][CDB_BITS-1:0] complete_dest_tag;
  logic [N_WAY-1:0]               wr_en;
  logic [N_WAY-1:0][CDB_BITS-1:0] wr_idx;
  logic [N_WAY-1:0][XLEN-1:0]     wr_data;

  modport master (
    output ex_valid, ex_dest_tag, ex_result,
    input  ex_stall, complete_dest_tag, wr_en, wr_idx, wr_data
  );

  modport slave (
    input  ex_valid, ex_dest_tag, ex_result,
    output ex_stall, complete_dest_tag, wr_en, wr_idx, wr_data
  );
endinterface

// File: rtl/cdb_complete_buffer.sv
// Complete stage: in-order circular buffer from N_EX execute lanes to N_WAY CDB lanes.
// Optional debug counters (o_stall_cycles, o_peak_count) under `define CDB_STALL_CNT_EN.
module cdb_complete_buffer #(
  parameter int N_EX     = 3,
  parameter int N_WAY    = 2,
  parameter int CDB_BITS = 6,
  parameter int XLEN     = 32,
  parameter int DEPTH    = 8
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  cdb_complete_buffer_if.slave   bus,
  output logic [$clog2(DEPTH):0] o_count
`ifdef CDB_STALL_CNT_EN
  ,
  output logic [31:0]            o_stall_cycles,
  output logic [$clog2(DEPTH):0] o_peak_count
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;

  logic [CDB_BITS-1:0]            r_fifo_tag  [DEPTH];
  logic [XLEN-1:0]                r_fifo_data [DEPTH];
  logic [PW-1:0]                  r_head;
  logic [PW-1:0]                  r_tail;
  logic [CW-1:0]                  r_count;
  logic [N_WAY-1:0][CDB_BITS-1:0] r_cdb_tag;
  logic [N_WAY-1:0][XLEN-1:0]     r_wr_data;
  logic [N_WAY-1:0]               r_wr_en;

  logic                           w_stall;
  logic [N_EX-1:0]                w_acc;
  logic [SW-1:0]                  w_rank [N_EX];
  logic [SW-1:0]                  w_cnt;
  logic [SW-1:0]                  w_n_in;
  logic [SW-1:0]                  w_n_tot;
  logic [SW-1:0]                  w_n_out;
  logic [SW-1:0]                  w_n_deq;
  logic [SW-1:0]                  w_n_bc_in;
  logic [SW-1:0]                  w_n_enq;
  logic [SW-1:0]                  w_count_next;
  logic [N_WAY-1:0][CDB_BITS-1:0] w_cdb_tag;
  logic [N_WAY-1:0][XLEN-1:0]     w_cdb_data;
  logic [N_WAY-1:0]               w_cdb_en;

  assign w_cnt   = SW'(r_count);
  // Stall depends only on the registered count, never on ex_valid.
  assign w_stall = (w_cnt + SW'(N_EX)) > SW'(DEPTH);

  always_comb begin
    w_n_in = '0;
    for (int i = 0; i < N_EX; i++) begin
      w_acc[i]  = bus.ex_valid[i] && (bus.ex_dest_tag[i] != '0) && !w_stall;
      w_rank[i] = w_n_in;
      if (w_acc[i]) w_n_in = w_n_in + SW'(1);
    end
    w_n_tot      = w_cnt + w_n_in;
    w_n_out      = (w_n_tot > SW'(N_WAY)) ? SW'(N_WAY) : w_n_tot;
    w_n_deq      = (w_cnt > SW'(N_WAY)) ? SW'(N_WAY) : w_cnt;
    w_n_bc_in    = w_n_out - w_n_deq;
    w_n_enq      = w_n_in - w_n_bc_in;
    w_count_next = w_n_tot - w_n_out;

    // Buffered entries win the low CDB lanes; incoming lanes bypass only when the FIFO runs short.
    for (int j = 0; j < N_WAY; j++) begin
      w_cdb_tag[j]  = '0;
      w_cdb_data[j] = '0;
      w_cdb_en[j]   = 1'b0;
      if (SW'(j) < w_n_deq) begin
        w_cdb_tag[j]  = r_fifo_tag[r_head + PW'(j)];
        w_cdb_data[j] = r_fifo_data[r_head + PW'(j)];
        w_cdb_en[j]   = 1'b1;
      end else begin
        for (int i = 0; i < N_EX; i++) begin
          if (w_acc[i] && ((w_cnt + w_rank[i]) == SW'(j))) begin
            w_cdb_tag[j]  = bus.ex_dest_tag[i];
            w_cdb_data[j] = bus.ex_result[i];
            w_cdb_en[j]   = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_cdb_tag <= '0;
      r_wr_data <= '0;
      r_wr_en   <= '0;
    end else begin
      r_head    <= r_head + PW'(w_n_deq);
      r_tail    <= r_tail + PW'(w_n_enq);
      r_count   <= CW'(w_count_next);
      r_cdb_tag <= w_cdb_tag;
      r_wr_data <= w_cdb_data;
      r_wr_en   <= w_cdb_en;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge i_clock) begin
    for (int i = 0; i < N_EX; i++) begin
      if (w_acc[i] && (w_rank[i] >= w_n_bc_in)) begin
        r_fifo_tag[r_tail + PW'(w_rank[i] - w_n_bc_in)]  <= bus.ex_dest_tag[i];
        r_fifo_data[r_tail + PW'(w_rank[i] - w_n_bc_in)] <= bus.ex_result[i];
      end
    end
  end

  assign bus.ex_stall          = w_stall;
  assign bus.complete_dest_tag = r_cdb_tag;
  assign bus.wr_idx            = r_cdb_tag;
  assign bus.wr_en             = r_wr_en;
  assign bus.wr_data           = r_wr_data;
  assign o_count               = r_count;

`ifdef CDB_STALL_CNT_EN
  logic [31:0]   r_stall_cycles;
  logic [CW-1:0] r_peak_count;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_stall_cycles <= '0;
      r_peak_count   <= '0;
    end else begin
      if (w_stall && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (CW'(w_count_next) > r_peak_count) r_peak_count <= CW'(w_count_next);
    end
  end

  assign o_stall_cycles = r_stall_cycles;
  assign o_peak_count   = r_peak_count;
`endif
endmodule

// File: tb/tb_cdb_complete_buffer.sv
// Directed bench for cdb_complete_buffer: reset, bypass, tag-0 drop, congestion, drain, wrap, mid-run reset.
module tb_cdb_complete_buffer;
  localparam int N_EX     = 3;
  localparam int N_WAY    = 2;
  localparam int CDB_BITS = 6;
  localparam int XLEN     = 32;
  localparam int DEPTH    = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] count;
`ifdef CDB_STALL_CNT_EN
  logic [31:0] stall_cycles;
  logic [3:0]  peak_count;
`endif

  always #5 clk = ~clk;

  cdb_complete_buffer_if #(.N_EX(N_EX), .N_WAY(N_WAY), .CDB_BITS(CDB_BITS), .XLEN(XLEN)) bus ();

  cdb_complete_buffer #(
    .N_EX(N_EX), .N_WAY(N_WAY), .CDB_BITS(CDB_BITS), .XLEN(XLEN), .DEPTH(DEPTH)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .bus(bus),
    .o_count(count)
`ifdef CDB_STALL_CNT_EN
    ,
    .o_stall_cycles(stall_cycles),
    .o_peak_count(peak_count)
`endif
  );

  int          total = 0;
  int          bad   = 0;
  int          n_tag = 0;
  logic [37:0] q[$];
  logic [37:0] e;
  logic        exp_stall;
  logic [5:0]  tg;
  logic [31:0] dt;
  logic [2:0]  pats [5] = '{3'b111, 3'b101, 3'b110, 3'b011, 3'b111};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] v, input logic [5:0] t0, input logic [5:0] t1,
                       input logic [5:0] t2);
    bus.ex_valid       = v;
    bus.ex_dest_tag[0] = t0;
    bus.ex_dest_tag[1] = t1;
    bus.ex_dest_tag[2] = t2;
    bus.ex_result[0]   = 32'h1000 + 32'(t0);
    bus.ex_result[1]   = 32'h1000 + 32'(t1);
    bus.ex_result[2]   = 32'h1000 + 32'(t2);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_en"}, bus.wr_en, 2'b00);
    chk({tag, "_tag0"}, bus.complete_dest_tag[0], 6'd0);
    chk({tag, "_tag1"}, bus.complete_dest_tag[1], 6'd0);
  endtask

  initial begin
    // Reset held two cycles with all lanes valid.
    rst = 1'b1;
    drive(3'b111, 6'd7, 6'd8, 6'd9);
    tick();
    tick();
    chk_idle("rst");
    chk("rst_count", count, 4'd0);
    chk("rst_stall", bus.ex_stall, 1'b0);
    chk("rst_data0", bus.wr_data[0], 32'd0);
    rst = 1'b0;
    drive(3'b000, 6'd0, 6'd0, 6'd0);
    tick();
    chk_idle("post_rst");

    // Single result bypasses straight to CDB lane 0.
    bus.ex_valid       = 3'b001;
    bus.ex_dest_tag[0] = 6'd5;
    bus.ex_result[0]   = 32'hDEAD;
    tick();
    chk("single_tag0", bus.complete_dest_tag[0], 6'd5);
    chk("single_en", bus.wr_en, 2'b01);
    chk("single_idx0", bus.wr_idx[0], 6'd5);
    chk("single_data0", bus.wr_data[0], 32'hDEAD);
    chk("single_tag1", bus.complete_dest_tag[1], 6'd0);
    chk("single_count", count, 4'd0);
    drive(3'b000, 6'd0, 6'd0, 6'd0);
    tick();
    chk_idle("single_after");
    chk("single_after_count", count, 4'd0);

    // Valid lane with tag 0 is dropped.
    drive(3'b011, 6'd0, 6'd9, 6'd0);
    tick();
    chk("drop_tag0", bus.complete_dest_tag[0], 6'd9);
    chk("drop_data0", bus.wr_data[0], 32'h1009);
    chk("drop_tag1", bus.complete_dest_tag[1], 6'd0);
    chk("drop_en", bus.wr_en, 2'b01);
    chk("drop_count", count, 4'd0);
    drive(3'b000, 6'd0, 6'd0, 6'd0);
    tick();

    // Congestion: 3 in, 2 out per cycle until stall.
    for (int k = 0; k < 6; k++) begin
      chk("cong_stall_lo", bus.ex_stall, 1'b0);
      drive(3'b111, 6'(3*k+1), 6'(3*k+2), 6'(3*k+3));
      tick();
      chk("cong_count", count, 4'(k+1));
      chk("cong_tag0", bus.complete_dest_tag[0], 6'(2*k+1));
      chk("cong_tag1", bus.complete_dest_tag[1], 6'(2*k+2));
      chk("cong_data1", bus.wr_data[1], 32'h1000 + 32'(2*k+2));
      chk("cong_en", bus.wr_en, 2'b11);
    end
    chk("cong_stall_hi", bus.ex_stall, 1'b1);
    drive(3'b000, 6'd0, 6'd0, 6'd0);

    // Drain the six buffered results.
    for (int d = 0; d < 3; d++) begin
      tick();
      chk("drain_count", count, 4'(4 - 2*d));
      chk("drain_tag0", bus.complete_dest_tag[0], 6'(13 + 2*d));
      chk("drain_tag1", bus.complete_dest_tag[1], 6'(14 + 2*d));
      chk("drain_stall", bus.ex_stall, 1'b0);
    end
    tick();
    chk_idle("drain_idle");
    chk("drain_count_end", count, 4'd0);

    // Long run with mixed lane patterns; wraps the pointers many times.
    for (int c = 0; c < 60; c++) begin
      exp_stall = (DEPTH - q.size()) < N_EX;
      chk("wrap_stall", bus.ex_stall, exp_stall);
      drive(3'b000, 6'd0, 6'd0, 6'd0);
      if (!exp_stall && c < 50) begin
        bus.ex_valid = pats[c % 5];
        for (int i = 0; i < N_EX; i++) begin
          if (pats[c % 5][i]) begin
            tg = 6'((n_tag % 63) + 1);
            dt = 32'hC0DE_0000 | 32'(n_tag);
            n_tag++;
            bus.ex_dest_tag[i] = tg;
            bus.ex_result[i]   = dt;
            q.push_back({dt, tg});
          end
        end
      end
      tick();
      for (int j = 0; j < N_WAY; j++) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("wrap_tag", bus.complete_dest_tag[j], e[5:0]);
          chk("wrap_data", bus.wr_data[j], e[37:6]);
          chk("wrap_en", bus.wr_en[j], 1'b1);
        end else begin
          chk("wrap_en_idle", bus.wr_en[j], 1'b0);
        end
      end
      chk("wrap_count", count, q.size());
    end

    // Build count=5, then reset mid-run.
    for (int k = 0; k < 5; k++) begin
      drive(3'b111, 6'(40 + 3*k), 6'(41 + 3*k), 6'(42 + 3*k));
      tick();
    end
    chk("pre_rst_count", count, 4'd5);
    drive(3'b000, 6'd0, 6'd0, 6'd0);
    rst = 1'b1;
    tick();
    chk("mid_rst_count", count, 4'd0);
    chk_idle("mid_rst");
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("post_mid_rst_en", bus.wr_en, 2'b00);
      chk("post_mid_rst_count", count, 4'd0);
    end
    drive(3'b100, 6'd0, 6'd0, 6'd33);
    tick();
    chk("fresh_tag0", bus.complete_dest_tag[0], 6'd33);
    chk("fresh_en", bus.wr_en, 2'b01);
    drive(3'b000, 6'd0, 6'd0, 6'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
